timestep_sequencer: RTL and testbench
=====================================

// Module: timestep_sequencer
// PURPOSE
//  Upstream controller for the neuron core. Runs a requested number of simulation timesteps.
//  Each timestep: sweeps neuron tags 0..numneurons-1, one per cycle, onto the core's tag input.
//  Then waits out the Izhikevich pipeline latency and waits for the core to report idle
//  (spike FIFO empty and CIM not busy). Finally pulses the CIM current-buffer swap.
// PARAMETERS
//  tagbits     1               width of neuron tag
//  numneurons  2**tagbits      neurons swept per timestep (<= 2**tagbits)
//  stepbits    16              width of step counter / step request
//  pipe_lat    4               cycles from last tag issued until its fire result can reach the FIFO
// PORTS
//  in_clk           input   1          single clock, all state on rising edge
//  in_asyn_reset_n  input   1          asynchronous, active-low reset
//  in_start         input   1          start a run; sampled only in IDLE
//  in_num_steps     input   stepbits   timesteps to run; latched when in_start is accepted
//  in_core_idle     input   1          core idle: FIFO empty AND CIM not busy
//  out_tag          output  tagbits    neuron tag presented to SR/FIFO/CIM
//  out_tag_valid    output  1          high while out_tag is a live update slot (SWEEP)
//  out_swap         output  1          1-cycle swap pulse to CIM
//  out_running      output  1          high in every state except IDLE
//  out_done         output  1          1-cycle pulse when the run completes
//  out_step_count   output  stepbits   number of completed timesteps in the current/last run
// BEHAVIOUR
//  Reset (async, low): state=IDLE; out_tag=0, out_tag_valid=0, out_swap=0, out_running=0,
//   out_done=0, out_step_count=0; internal latched step target=0; latency counter=0.
//  States: IDLE -> SWEEP -> FLUSH -> DRAIN -> SWAP -> (SWEEP | DONE) -> IDLE.
//  IDLE: on in_start=1, latch in_num_steps and clear out_step_count.
//   - If in_num_steps==0: go to DONE. No sweep, no swap.
//   - Otherwise: go to SWEEP with out_tag=0.
//  SWEEP: out_tag_valid=1; out_tag increments by 1 each cycle.
//   - After tag numneurons-1 is presented (exactly numneurons cycles): go to FLUSH.
//   - out_tag returns to 0 and is held at 0 in all other states.
//  FLUSH: count pipe_lat cycles, then go to DRAIN. in_core_idle is ignored here.
//  DRAIN: wait while in_core_idle==0. On the first cycle with in_core_idle==1, go to SWAP.
//  SWAP: out_swap=1 for exactly this cycle; out_step_count increments.
//   - If the new count equals the latched target: go to DONE.
//   - Otherwise: go to SWEEP, with tag 0 on the next cycle.
//  DONE: out_done=1 for one cycle, then IDLE. out_step_count holds its final value until the next start.
//  Step count arithmetic: stepbits unsigned.
//   - Target 2**stepbits-1 is legal.
//   - The counter never wraps inside a run because the compare happens before the next increment.
//  Simultaneous events and mid-run conditions:
//   - in_start while not IDLE is ignored; it is neither queued nor restarts the run.
//   - in_num_steps changes mid-run have no effect.
//  Reset mid-run: everything returns immediately to reset values; the swap pulse is truncated.
//   No done pulse is generated.
//  Latency: the first out_tag_valid occurs on the cycle after in_start is accepted.
//   One timestep = numneurons + pipe_lat + (DRAIN cycles >= 1) + 1 cycles.
//  out_running equals (state != IDLE) and is registered. All outputs are registered (no comb paths from inputs).
// CONFIGURATION
//  DRAIN_TIMEOUT_EN defined:
//   - Adds parameter timeout_cycles (default 1024) and output out_timeout (1 bit, reset 0).
//   - If DRAIN lasts timeout_cycles consecutive cycles: out_timeout is set and latched until
//     the next accepted in_start or reset. The FSM goes to DONE; out_done pulses and no swap occurs.
//  DRAIN_TIMEOUT_EN undefined: no out_timeout port; DRAIN waits indefinitely.
// TESTING
//  Basic run: tagbits=1, pipe_lat=4, in_core_idle tied 1, start with num_steps=3.
//   -> tags 0,1 valid per step; 3 swap pulses 8 cycles apart (2+4+1+1);
//      out_done one cycle after the 3rd swap; out_step_count=3.
//  Zero-step request: start with num_steps=0.
//   -> out_done on the next cycle; out_swap never asserted; out_tag_valid never asserted.
//  Drain stall: in_core_idle=0 for 10 cycles after FLUSH.
//   -> swap delayed exactly 10 cycles, then exactly one swap pulse.
//  Ignored start: pulse in_start and change in_num_steps mid-run.
//   -> run length unchanged; no restart; exactly one out_done.
//  Async reset mid-run: assert in_asyn_reset_n low during SWEEP, between clock edges.
//   -> all outputs 0 immediately; after release the block stays IDLE until in_start.
//  DRAIN_TIMEOUT_EN with timeout_cycles=16, in_core_idle held 0.
//   -> out_timeout=1 after 16 DRAIN cycles; out_done pulses; out_swap stays 0; out_step_count=0.

Source files
------------

// File: rtl/timestep_sequencer.sv
`default_nettype none
// timestep_sequencer: per timestep sweeps neuron tags, waits pipe latency and core idle, then pulses the CIM swap.
// Optional DRAIN_TIMEOUT_EN adds a DRAIN watchdog (timeout_cycles) and the out_timeout flag. Rev 1.0
module timestep_sequencer #(
  parameter int tagbits    = 1,
  parameter int numneurons = 2**tagbits,
  parameter int stepbits   = 16,
  parameter int pipe_lat   = 4
`ifdef DRAIN_TIMEOUT_EN
  , parameter int timeout_cycles = 1024
`endif
) (
  input  logic                in_clk,
  input  logic                in_asyn_reset_n,
  input  logic                in_start,
  input  logic [stepbits-1:0] in_num_steps,
  input  logic                in_core_idle,
  output logic [tagbits-1:0]  out_tag,
  output logic                out_tag_valid,
  output logic                out_swap,
  output logic                out_running,
  output logic                out_done,
  output logic [stepbits-1:0] out_step_count
`ifdef DRAIN_TIMEOUT_EN
  , output logic              out_timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SWEEP = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    SWAP  = 3'd4,
    DONE  = 3'd5
  } state_t;

`ifdef DRAIN_TIMEOUT_EN
  localparam int CNT_MAX = (timeout_cycles > pipe_lat) ? timeout_cycles : pipe_lat;
`else
  localparam int CNT_MAX = pipe_lat;
`endif
  localparam int CNTW = $clog2(CNT_MAX + 1);
  localparam logic [CNTW-1:0]    FLUSH_LAST = CNTW'(pipe_lat - 1);
  localparam logic [tagbits-1:0] LAST_TAG   = tagbits'(numneurons - 1);
`ifdef DRAIN_TIMEOUT_EN
  localparam logic [CNTW-1:0]    DRAIN_LAST = CNTW'(timeout_cycles - 1);
`endif

  state_t              state, state_nx;
  logic [tagbits-1:0]  tag_nx;
  logic [CNTW-1:0]     cnt, cnt_nx;
  logic [stepbits-1:0] target, target_nx, count_nx;
`ifdef DRAIN_TIMEOUT_EN
  logic                timeout_nx;
`endif

  always_comb begin
    state_nx  = state;
    tag_nx    = '0;
    cnt_nx    = cnt;
    target_nx = target;
    count_nx  = out_step_count;
`ifdef DRAIN_TIMEOUT_EN
    timeout_nx = out_timeout;
`endif
    case (state)
      IDLE: begin
        if (in_start) begin
          target_nx = in_num_steps;
          count_nx  = '0;
`ifdef DRAIN_TIMEOUT_EN
          timeout_nx = 1'b0;
`endif
          state_nx  = (in_num_steps == '0) ? DONE : SWEEP;
        end
      end
      SWEEP: begin
        if (out_tag == LAST_TAG) begin
          state_nx = FLUSH;
          cnt_nx   = '0;
        end else begin
          tag_nx = out_tag + tagbits'(1);
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNTW'(1);
        end
      end
      DRAIN: begin
        if (in_core_idle) begin
          state_nx = SWAP;
          count_nx = out_step_count + stepbits'(1);
`ifdef DRAIN_TIMEOUT_EN
        end else if (cnt == DRAIN_LAST) begin
          state_nx   = DONE;
          timeout_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNTW'(1);
`endif
        end
      end
      // Count was bumped on entry, so the compare sees the new value before any further increment.
      SWAP:    state_nx = (out_step_count == target) ? DONE : SWEEP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_asyn_reset_n) begin
    if (!in_asyn_reset_n) begin
      state          <= IDLE;
      out_tag        <= '0;
      out_tag_valid  <= 1'b0;
      out_swap       <= 1'b0;
      out_running    <= 1'b0;
      out_done       <= 1'b0;
      out_step_count <= '0;
      target         <= '0;
      cnt            <= '0;
`ifdef DRAIN_TIMEOUT_EN
      out_timeout    <= 1'b0;
`endif
    end else begin
      state          <= state_nx;
      out_tag        <= tag_nx;
      out_tag_valid  <= (state_nx == SWEEP);
      out_swap       <= (state_nx == SWAP);
      out_running    <= (state_nx != IDLE);
      out_done       <= (state_nx == DONE);
      out_step_count <= count_nx;
      target         <= target_nx;
      cnt            <= cnt_nx;
`ifdef DRAIN_TIMEOUT_EN
      out_timeout    <= timeout_nx;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timestep_sequencer.sv
`default_nettype none
// tb_timestep_sequencer: randomized runs compared cycle by cycle against a schedule model of each timestep.
module tb_timestep_sequencer;

  localparam int TAGBITS  = 1;
  localparam int NUMN     = 2;
  localparam int STEPBITS = 16;
  localparam int PIPE     = 4;
  localparam int TO       = 16;
  localparam int L        = 512;
`ifdef DRAIN_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [STEPBITS-1:0] num_steps;
  logic                core_idle;
  logic [TAGBITS-1:0]  tag;
  logic                tag_valid, swap, running, done;
  logic [STEPBITS-1:0] step_count;
`ifdef DRAIN_TIMEOUT_EN
  logic                timeout;
`endif

  int checks = 0;
  int errors = 0;

  bit idle_a  [L];
  bit e_valid [L];
  int e_tag   [L];
  bit e_swap  [L];
  bit e_done  [L];
  bit e_run   [L];

  always #5 clk = ~clk;

  timestep_sequencer #(
    .tagbits    (TAGBITS),
    .numneurons (NUMN),
    .stepbits   (STEPBITS),
    .pipe_lat   (PIPE)
`ifdef DRAIN_TIMEOUT_EN
    , .timeout_cycles (TO)
`endif
  ) dut (
    .in_clk          (clk),
    .in_asyn_reset_n (rst_n),
    .in_start        (start),
    .in_num_steps    (num_steps),
    .in_core_idle    (core_idle),
    .out_tag         (tag),
    .out_tag_valid   (tag_valid),
    .out_swap        (swap),
    .out_running     (running),
    .out_done        (done),
    .out_step_count  (step_count)
`ifdef DRAIN_TIMEOUT_EN
    , .out_timeout   (timeout)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Idle modes: 0 always idle, 1 random, 2 busy for 10 cycles at each DRAIN entry, 3 never idle.
  task automatic run_one(input int n, input int mode, input bit glitch);
    int t, d, c, end_c, g, steps_done;
    bit to_hit;
    for (int i = 0; i < L; i++) begin
      case (mode)
        0:       idle_a[i] = 1'b1;
        1:       idle_a[i] = ($urandom_range(0, 1) == 1);
        2:       idle_a[i] = 1'b1;
        default: idle_a[i] = 1'b0;
      endcase
      e_valid[i] = 1'b0; e_tag[i] = 0; e_swap[i] = 1'b0; e_done[i] = 1'b0; e_run[i] = 1'b0;
    end
    steps_done = 0;
    to_hit     = 1'b0;
    end_c      = 1;
    if (n != 0) begin
      t = 1;
      for (int k = 0; k < n && !to_hit; k++) begin
        for (int i = 0; i < NUMN; i++) begin
          e_valid[t+i] = 1'b1;
          e_tag[t+i]   = i;
        end
        d = t + NUMN + PIPE;
        if (mode == 2) for (int i = 0; i < 10; i++) idle_a[d+i] = 1'b0;
        c = d;
        while (!idle_a[c] && !(TIMEOUT_ON && (c - d) >= TO) && c < L - 40) c++;
        if (TIMEOUT_ON && (c - d) >= TO) begin
          to_hit = 1'b1;
          end_c  = c;
        end else begin
          e_swap[c+1] = 1'b1;
          steps_done++;
          t = c + 2;
          end_c = t;
        end
      end
    end
    e_done[end_c] = 1'b1;
    for (int i = 1; i <= end_c; i++) e_run[i] = 1'b1;

    g = glitch ? int'($urandom_range(1, end_c)) : -1;
    for (int cy = 0; cy <= end_c + 3; cy++) begin
      @(posedge clk);
      #1;
      start = (cy == 0) || (cy == g);
      if (cy == 0) num_steps = STEPBITS'(n);
      else if (cy == g) num_steps = STEPBITS'($urandom);
      core_idle = idle_a[cy];
      @(negedge clk);
      check($sformatf("out@%0d", cy), {running, tag_valid, tag, swap, done},
            {e_run[cy], e_valid[cy], TAGBITS'(e_tag[cy]), e_swap[cy], e_done[cy]});
      if (cy == 1) check("count_clear", step_count, 0);
      if (cy == end_c + 2) check("count_final", step_count, steps_done);
`ifdef DRAIN_TIMEOUT_EN
      if (cy == 1) check("timeout_clear", timeout, 0);
      if (cy == end_c + 2) check("timeout_final", timeout, to_hit);
`endif
    end
    start = 1'b0;
  endtask

  task automatic reset_mid_run();
    @(posedge clk); #1;
    start = 1'b1; num_steps = 3; core_idle = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("sweep_before_rst", {running, tag_valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {running, tag_valid, tag, swap, done, step_count}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {running, tag_valid, tag, swap, done, step_count}, 0);
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; num_steps = '0; core_idle = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {running, tag_valid, tag, swap, done, step_count}, 0);
`ifdef DRAIN_TIMEOUT_EN
    check("reset_timeout", timeout, 0);
`endif
    rst_n = 1'b1;

    run_one(3, 0, 1'b0);
    run_one(0, 0, 1'b0);
    run_one(2, 2, 1'b0);
    run_one(3, 0, 1'b1);
    run_one(1, 0, 1'b1);
    reset_mid_run();
`ifdef DRAIN_TIMEOUT_EN
    run_one(2, 3, 1'b0);
    run_one(1, 0, 1'b0);
`endif
    for (int i = 0; i < 25; i++)
      run_one(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
